// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC bus scheduler: the bus-cycle state encoding,
// RTC register address map and default bus timing.
package rtc_bus_pkg;

  // Bus-cycle phases, in the order they occur within one transaction.
  typedef enum logic [2:0] {
    IDLE,
    A_SETUP,
    A_STROBE,
    A_HOLD,
    D_SETUP,
    D_STROBE,
    D_HOLD,
    TURN
  } state_t;

  // RTC register addresses used by the field blocks.
  localparam logic [7:0] RTC_ADDR_SECONDS = 8'h20;
  localparam logic [7:0] RTC_ADDR_MINUTES = 8'h21;
  localparam logic [7:0] RTC_ADDR_HOURS   = 8'h22;
  localparam logic [7:0] RTC_ADDR_DATE    = 8'h23;
  localparam logic [7:0] RTC_ADDR_COMMAND = 8'h2F;

  // Default requester count and bus timing, in clk cycles.
  localparam int NREQ_DEF     = 4;
  localparam int T_SETUP_DEF  = 1;
  localparam int T_STROBE_DEF = 4;
  localparam int T_HOLD_DEF   = 1;

  // Largest of three phase lengths; sizes the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rtc_rr_arbiter.sv
// Combinational requester pick for the RTC bus scheduler.
// Default: round-robin starting at i_ptr (wrapping).
// With RTC_FIXED_PRIORITY_EN defined: fixed priority, requester 0 highest,
// and i_ptr is ignored.
module rtc_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_valid
);

  assign o_valid = |i_req;

`ifdef RTC_FIXED_PRIORITY_EN
  // Scan from the highest index down so the lowest active index wins last.
  // NOTE: every output is given a default before the loop, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (i_req[IW'(k)]) begin
        o_grant        = '0;
        o_grant[IW'(k)] = 1'b1;
        o_idx          = IW'(k);
      end
    end
  end
`else
  logic          w_found;
  logic [IW-1:0] w_j;

  // Walk the requesters starting at the pointer and take the first active one.
  // NOTE: every output is given a default before the loop, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = IW'((int'(i_ptr) + k) % NREQ);
      if (!w_found && i_req[w_j]) begin
        o_grant[w_j] = 1'b1;
        o_idx        = w_j;
        w_found      = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/rtc_bus_scheduler.sv
// Shares the multiplexed 8-bit RTC bus (CS/AD/RD/WR, active-low) between
// NREQ field blocks. One winner per transaction runs a full address phase
// and data phase; read data and a done pulse are returned to it.
// All pin-facing outputs are registered (decoded from the next state) so
// the strobes are glitch-free.
// Optional: define RTC_FIXED_PRIORITY_EN for fixed priority (requester 0
// highest) instead of round-robin; bus timing is unchanged.
module rtc_bus_scheduler
  import rtc_bus_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int T_SETUP  = T_SETUP_DEF,
  parameter int T_STROBE = T_STROBE_DEF,
  parameter int T_HOLD   = T_HOLD_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] req_rnw,
  input  logic [NREQ*8-1:0] req_addr,
  input  logic [NREQ*8-1:0] req_wdata,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] done,
  output logic [7:0]      rdata,
  output logic            busy,
  output logic [7:0]      bus_dout,
  output logic            bus_oe,
  input  logic [7:0]      bus_din,
  output logic            CS,
  output logic            AD,
  output logic            RD,
  output logic            WR
);

  localparam int CW = $clog2(max3(T_SETUP, T_STROBE, T_HOLD) + 1);
  localparam int IW = $clog2(NREQ);

  state_t          r_state, w_next_state;
  logic [CW-1:0]   r_cnt;
  logic            w_last;

  logic [IW-1:0]   r_ptr, r_owner, w_arb_idx;
  logic [NREQ-1:0] w_arb_grant, r_grant;
  logic            w_arb_valid;

  logic            r_rnw;
  logic [7:0]      r_addr, r_wdata, r_rdata;
  logic [7:0]      w_sel_addr, w_sel_wdata, w_a_addr;
  logic            w_sel_rnw;

  logic            r_cs, r_ad, r_rd, r_wr, r_oe, r_busy;
  logic [7:0]      r_dout;
  logic [NREQ-1:0] r_done;
  logic            w_cs, w_ad, w_rd, w_wr, w_oe, w_busy;
  logic [7:0]      w_dout;
  logic [NREQ-1:0] w_done;

  rtc_rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  assign w_sel_addr  = req_addr[8*int'(w_arb_idx) +: 8];
  assign w_sel_wdata = req_wdata[8*int'(w_arb_idx) +: 8];
  assign w_sel_rnw   = req_rnw[w_arb_idx];
  // A_SETUP is entered straight from IDLE, before the address is latched.
  assign w_a_addr    = (r_state == IDLE) ? w_sel_addr : r_addr;

  // Flag the final cycle of the current timed phase.
  always_comb begin
    w_last = 1'b1;
    case (r_state)
      A_SETUP, D_SETUP:   w_last = (r_cnt == CW'(T_SETUP - 1));
      A_STROBE, D_STROBE: w_last = (r_cnt == CW'(T_STROBE - 1));
      A_HOLD, D_HOLD:     w_last = (r_cnt == CW'(T_HOLD - 1));
      default:            w_last = 1'b1;
    endcase
  end

  // Next-state logic: walk the phases in order once a requester wins.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:     if (w_arb_valid) w_next_state = A_SETUP;
      A_SETUP:  if (w_last) w_next_state = A_STROBE;
      A_STROBE: if (w_last) w_next_state = A_HOLD;
      A_HOLD:   if (w_last) w_next_state = D_SETUP;
      D_SETUP:  if (w_last) w_next_state = D_STROBE;
      D_STROBE: if (w_last) w_next_state = D_HOLD;
      D_HOLD:   if (w_last) w_next_state = TURN;
      TURN:     w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  // Pin values for the state being entered; registered below.
  always_comb begin
    w_cs   = 1'b1;
    w_ad   = 1'b1;
    w_rd   = 1'b1;
    w_wr   = 1'b1;
    w_oe   = 1'b0;
    w_dout = '0;
    w_done = '0;
    w_busy = (w_next_state != IDLE);
    case (w_next_state)
      A_SETUP, A_STROBE, A_HOLD: begin
        w_cs   = 1'b0;
        w_ad   = 1'b0;
        w_oe   = 1'b1;
        w_dout = w_a_addr;
        w_wr   = (w_next_state != A_STROBE);
      end
      D_SETUP, D_STROBE, D_HOLD: begin
        w_cs = 1'b0;
        if (!r_rnw) begin
          w_oe   = 1'b1;
          w_dout = r_wdata;
        end
        if (w_next_state == D_STROBE) begin
          w_rd = !r_rnw;
          w_wr = r_rnw;
        end
      end
      TURN:    w_done = r_grant;
      default: ;
    endcase
  end

  // State register and phase counter; the counter restarts on every phase change.
  // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if ((w_next_state != r_state) || (r_state == IDLE)) r_cnt <= '0;
      else                                                r_cnt <= r_cnt + CW'(1);
    end
  end

  // Latch the winner's request, track ownership and advance the RR pointer.
  // NOTE: the latched payload is reset as well so it never carries X into the bus decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rnw   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_grant <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_rdata <= '0;
    end else begin
      if ((r_state == IDLE) && w_arb_valid) begin
        r_rnw   <= w_sel_rnw;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
        r_grant <= w_arb_grant;
        r_owner <= w_arb_idx;
      end else if (r_state == TURN) begin
        r_grant <= '0;
        r_ptr   <= (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + IW'(1);
      end
      if ((r_state == D_STROBE) && w_last && r_rnw) r_rdata <= bus_din;
    end
  end

  // Output registers; reset drives every strobe high and releases the bus at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cs   <= 1'b1;
      r_ad   <= 1'b1;
      r_rd   <= 1'b1;
      r_wr   <= 1'b1;
      r_oe   <= 1'b0;
      r_dout <= '0;
      r_done <= '0;
      r_busy <= 1'b0;
    end else begin
      r_cs   <= w_cs;
      r_ad   <= w_ad;
      r_rd   <= w_rd;
      r_wr   <= w_wr;
      r_oe   <= w_oe;
      r_dout <= w_dout;
      r_done <= w_done;
      r_busy <= w_busy;
    end
  end

  assign CS       = r_cs;
  assign AD       = r_ad;
  assign RD       = r_rd;
  assign WR       = r_wr;
  assign bus_oe   = r_oe;
  assign bus_dout = r_dout;
  assign done     = r_done;
  assign busy     = r_busy;
  assign grant    = r_grant;
  assign rdata    = r_rdata;

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Self-checking bench for rtc_bus_scheduler (defaults: NREQ=4, 1/4/1 timing).
// A transaction-level model predicts every pin from the offset into the
// current transaction; directed tests pin the model with literal values.
module tb_rtc_bus_scheduler;
  import rtc_bus_pkg::*;

  localparam int NREQ      = 4;
  localparam int TS        = 1;
  localparam int TST       = 4;
  localparam int TH        = 1;
  localparam int P         = TS + TST + TH;
  localparam int TURN_OFF  = 2 * P;
  localparam int SAMPLE_OFF = P + TS + TST - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [NREQ-1:0] req, req_rnw;
  logic [NREQ*8-1:0] req_addr, req_wdata;
  logic [NREQ-1:0] grant, done;
  logic [7:0]      rdata, bus_dout, bus_din;
  logic            busy, bus_oe, CS, AD, RD, WR;

  int n_vec = 0;
  int n_bad = 0;

  rtc_bus_scheduler #(
    .NREQ(NREQ), .T_SETUP(TS), .T_STROBE(TST), .T_HOLD(TH)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_rnw(req_rnw),
    .req_addr(req_addr), .req_wdata(req_wdata), .grant(grant), .done(done),
    .rdata(rdata), .busy(busy), .bus_dout(bus_dout), .bus_oe(bus_oe),
    .bus_din(bus_din), .CS(CS), .AD(AD), .RD(RD), .WR(WR)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit         m_active;
  int         m_off, m_owner, m_ptr;
  bit         m_rnw;
  logic [7:0] m_addr, m_wdata, m_rdata;

  function automatic int pick(input logic [NREQ-1:0] r, input int ptr);
    int w;
    w = -1;
`ifdef RTC_FIXED_PRIORITY_EN
    for (int k = NREQ - 1; k >= 0; k--) if (r[k]) w = k;
`else
    for (int k = NREQ - 1; k >= 0; k--) if (r[(ptr + k) % NREQ]) w = (ptr + k) % NREQ;
`endif
    return w;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active <= 1'b0;
      m_off    <= 0;
      m_ptr    <= 0;
      m_rdata  <= '0;
    end else if (!m_active) begin
      if (req != '0) begin
        m_owner  <= pick(req, m_ptr);
        m_rnw    <= req_rnw[pick(req, m_ptr)];
        m_addr   <= req_addr[8*pick(req, m_ptr) +: 8];
        m_wdata  <= req_wdata[8*pick(req, m_ptr) +: 8];
        m_active <= 1'b1;
        m_off    <= 0;
      end
    end else begin
      if (m_off == SAMPLE_OFF && m_rnw) m_rdata <= bus_din;
      if (m_off == TURN_OFF) begin
        m_active <= 1'b0;
        m_ptr    <= (m_owner + 1) % NREQ;
      end else begin
        m_off <= m_off + 1;
      end
    end
  end

  typedef struct packed {
    logic cs, ad, rd, wr, oe, busy, grant_chk, rd_chk;
    logic [7:0] dout;
    logic [NREQ-1:0] grant, done;
  } exp_t;

  function automatic exp_t expect_now();
    exp_t e;
    int d;
    e = '0;
    e.cs = 1'b1; e.ad = 1'b1; e.rd = 1'b1; e.wr = 1'b1; e.grant_chk = 1'b1;
    if (m_active) begin
      e.busy = 1'b1;
      if (m_off < TURN_OFF) begin
        e.cs    = 1'b0;
        e.grant = NREQ'(1 << m_owner);
        if (m_off < P) begin
          e.ad = 1'b0; e.oe = 1'b1; e.dout = m_addr;
          if (m_off >= TS && m_off < TS + TST) e.wr = 1'b0;
        end else begin
          d = m_off - P;
          if (!m_rnw) begin e.oe = 1'b1; e.dout = m_wdata; end
          if (d >= TS && d < TS + TST) begin
            if (m_rnw) e.rd = 1'b0;
            else       e.wr = 1'b0;
          end
        end
      end else begin
        e.done      = NREQ'(1 << m_owner);
        e.rd_chk    = m_rnw;
        e.grant_chk = 1'b0;
      end
    end
    return e;
  endfunction

  // Per-cycle compare of every output against the model.
  exp_t ex;
  always @(negedge clk) begin
    ex = expect_now();
    check("cs", CS, ex.cs);
    check("ad", AD, ex.ad);
    check("rd", RD, ex.rd);
    check("wr", WR, ex.wr);
    check("bus_oe", bus_oe, ex.oe);
    check("busy", busy, ex.busy);
    check("done", done, ex.done);
    if (ex.grant_chk) check("grant", grant, ex.grant);
    if (ex.oe)        check("bus_dout", bus_dout, ex.dout);
    if (ex.rd_chk)    check("rdata", rdata, m_rdata);
  end

  // ---------------- protocol monitor ----------------
  int   cs_run = 100;
  logic prev_cs = 1'b1;
  logic prev_stb = 1'b0;
  logic prev_ad = 1'b1;
  always @(negedge clk) begin
    check("mon_rd_wr_both_low", (!RD && !WR), 1'b0);
    check("mon_strobe_no_cs", ((!RD || !WR) && CS), 1'b0);
    if ((!RD || !WR) && prev_stb) check("mon_ad_stable", AD, prev_ad);
    if (!CS && prev_cs) check("mon_cs_gap", (cs_run >= 2), 1'b1);
    cs_run   = CS ? cs_run + 1 : 0;
    prev_cs  = CS;
    prev_stb = !RD || !WR;
    prev_ad  = AD;
  end

  // ---------------- directed stimulus ----------------
  // Starts in the IDLE cycle in which req is raised (cycle 1); done is
  // expected in cycle 14. Optionally, at cycle mut_cyc, the owner drops req
  // and scrambles its fields while extra_req is raised.
  task automatic run_txn(input int who, input int mut_cyc, input logic [NREQ-1:0] extra_req,
                         output int done_cyc, output int wr_a, output int wr_d,
                         output int rd_d, output int oe_d, output logic [7:0] dout_a,
                         output logic [7:0] dout_d, output logic [7:0] rd_v,
                         output logic [NREQ-1:0] g2);
    done_cyc = -1; wr_a = 0; wr_d = 0; rd_d = 0; oe_d = 0;
    dout_a = '0; dout_d = '0; rd_v = '0; g2 = '0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == mut_cyc) begin
        req[who]               = 1'b0;
        req_rnw[who]           = ~req_rnw[who];
        req_addr[8*who +: 8]   = 8'hEE;
        req_wdata[8*who +: 8]  = 8'h00;
        req                    = req | extra_req;
      end
      @(negedge clk);
      if (cyc == 2) g2 = grant;
      if (!CS && !AD && !WR) begin wr_a++; dout_a = bus_dout; end
      if (!CS && AD) begin
        if (!WR) wr_d++;
        if (!RD) rd_d++;
        if (bus_oe) begin oe_d++; dout_d = bus_dout; end
      end
      if (done[who]) begin
        done_cyc = cyc;
        rd_v     = rdata;
        break;
      end
      @(posedge clk); #1;
    end
    if (done_cyc < 0) check("txn_timeout", 0, 1);
    @(posedge clk); #1;
    req[who] = 1'b0;
  endtask

  int                dc, wa, wd, rdc, oed, n_done;
  logic [7:0]        da, dd, rv;
  logic [NREQ-1:0]   g;
  logic [NREQ-1:0]   seq [5];
  logic [NREQ-1:0]   cont_exp [5];

  initial begin
`ifdef RTC_FIXED_PRIORITY_EN
    cont_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    cont_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    reset = 1'b0; req = '0; req_rnw = '0; req_addr = '0; req_wdata = '0;
    bus_din = 8'h47;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", CS, 1'b1);   check("rst_ad", AD, 1'b1);
    check("rst_rd", RD, 1'b1);   check("rst_wr", WR, 1'b1);
    check("rst_oe", bus_oe, 1'b0); check("rst_dout", bus_dout, 8'h00);
    check("rst_grant", grant, 4'b0000); check("rst_done", done, 4'b0000);
    check("rst_rdata", rdata, 8'h00); check("rst_busy", busy, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Contention: all four requesters held high.
    for (int i = 0; i < NREQ; i++) begin
      req_addr[8*i +: 8]  = 8'h20 + 8'(i);
      req_wdata[8*i +: 8] = 8'hA0 + 8'(i);
    end
    req = 4'hF;
    n_done = 0;
    for (int cyc = 0; cyc < 120 && n_done < 5; cyc++) begin
      @(negedge clk);
      if (done != '0) begin seq[n_done] = done; n_done++; end
      if (n_done < 5) begin @(posedge clk); #1; end
    end
    check("cont_count", n_done, 5);
    for (int k = 0; k < 5; k++) if (k < n_done) check($sformatf("cont_owner_%0d", k), seq[k], cont_exp[k]);
    @(posedge clk); #1;
    req = '0;

    // Single write from requester 1.
    req_rnw[1] = 1'b0; req_addr[15:8] = RTC_ADDR_HOURS; req_wdata[15:8] = 8'h15; req[1] = 1'b1;
    run_txn(1, 0, '0, dc, wa, wd, rdc, oed, da, dd, rv, g);
    check("wr_grant", g, 4'b0010);    check("wr_done_cyc", dc, 14);
    check("wr_addr", da, 8'h22);      check("wr_data", dd, 8'h15);
    check("wr_a_low", wa, 4);         check("wr_d_low", wd, 4);
    check("wr_no_rd", rdc, 0);

    // Single read from requester 2.
    req_rnw[2] = 1'b1; req_addr[23:16] = RTC_ADDR_MINUTES; req[2] = 1'b1;
    run_txn(2, 0, '0, dc, wa, wd, rdc, oed, da, dd, rv, g);
    check("rd_grant", g, 4'b0100);    check("rd_done_cyc", dc, 14);
    check("rd_addr", da, 8'h21);      check("rd_low", rdc, 4);
    check("rd_oe_data", oed, 0);      check("rd_rdata", rv, 8'h47);
    check("rd_no_wr_d", wd, 0);

    // Owner 3 drops req and scrambles its fields during A_STROBE;
    // requester 0 (a read) arrives meanwhile and must follow cleanly.
    req_rnw[3] = 1'b0; req_addr[31:24] = RTC_ADDR_DATE; req_wdata[31:24] = 8'h5A; req[3] = 1'b1;
    req_rnw[0] = 1'b1; req_addr[7:0] = RTC_ADDR_COMMAND;
    run_txn(3, 3, 4'b0001, dc, wa, wd, rdc, oed, da, dd, rv, g);
    check("mut_done_cyc", dc, 14);    check("mut_addr", da, 8'h23);
    check("mut_data", dd, 8'h5A);     check("mut_wr_d_low", wd, 4);
    run_txn(0, 0, '0, dc, wa, wd, rdc, oed, da, dd, rv, g);
    check("b2b_done_cyc", dc, 14);    check("b2b_addr", da, 8'h2F);
    check("b2b_rdata", rv, 8'h47);

    // Reset pulsed in the middle of a write's D_STROBE.
    req_rnw[1] = 1'b0; req_addr[15:8] = RTC_ADDR_SECONDS; req_wdata[15:8] = 8'h33; req[1] = 1'b1;
    repeat (9) begin @(posedge clk); #1; end
    @(negedge clk);
    check("mid_wr_low", WR, 1'b0);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_cs", CS, 1'b1);    check("mid_rst_ad", AD, 1'b1);
    check("mid_rst_rd", RD, 1'b1);    check("mid_rst_wr", WR, 1'b1);
    check("mid_rst_oe", bus_oe, 1'b0); check("mid_rst_grant", grant, 4'b0000);
    check("mid_rst_done", done, 4'b0000);
    req[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    bus_din = 8'h9C;
    req_rnw[2] = 1'b1; req_addr[23:16] = RTC_ADDR_HOURS; req[2] = 1'b1;
    run_txn(2, 0, '0, dc, wa, wd, rdc, oed, da, dd, rv, g);
    check("post_rst_grant", g, 4'b0100); check("post_rst_done_cyc", dc, 14);
    check("post_rst_rdata", rv, 8'h9C);  check("post_rst_rd_low", rdc, 4);

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
